tbb: RTL and testbench

Task batch buffer: the load-side counterpart of the result batch buffer. It fetches one task batch of 2^TBB_WR_ADDR_WIDTH 512-bit lines from the host-side line fetcher using a ReqValid/ReqLineIdx/ReqAck handshake. It then serves the batch to one PE Array as 32-bit words by word address, and releases the buffer when the PE Array reports task_done. Storage is one nlb_gram_sdp instance (256 x 512 by default, 1-cycle registered read).

---
 rtl/tbb.sv | 148 ++++++++++++++
 tb/tb_tbb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbb.sv
// Task batch buffer: fetches one batch of 512-bit lines from the host-side
// line fetcher, then serves it to a PE Array as 32-bit words until task_done.

module nlb_gram_sdp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Simple dual-port array with a registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
    if (re) begin
      dout <= mem[raddr];
    end
  end

endmodule

module tbb #(
  parameter int TBB_WR_ADDR_WIDTH = 8,
  parameter int TBB_WR_DATA_WIDTH = 512,
  parameter int TBB_RD_ADDR_WIDTH = 12,
  parameter int TBB_RD_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_start,
  output logic                         ReqValid,
  output logic [TBB_WR_ADDR_WIDTH-1:0] ReqLineIdx,
  input  logic                         ReqAck,
  input  logic [TBB_WR_DATA_WIDTH-1:0] WrDin,
  input  logic                         RdEn,
  input  logic [TBB_RD_ADDR_WIDTH-1:0] RdAddr,
  output logic [TBB_RD_DATA_WIDTH-1:0] RdDout,
  output logic                         RdValid,
  input  logic                         task_done,
  output logic                         Full,
  output logic                         Empty,
  output logic                         TestCmp
);

  localparam int SelWidth = TBB_RD_ADDR_WIDTH - TBB_WR_ADDR_WIDTH;
  localparam int NumWords = 1 << SelWidth;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    FILL  = 3'b010,
    READY = 3'b100
  } state_t;

  state_t                         state;
  state_t                         nextState;
  logic [TBB_WR_ADDR_WIDTH-1:0]   wrCounter;
  logic                           wrEn;
  logic                           lastLine;
  logic                           rdAccept;
  logic                           rdValid1;
  logic [SelWidth-1:0]            wordSel1;
  logic [TBB_WR_DATA_WIDTH-1:0]   ramDout;
  logic [TBB_RD_DATA_WIDTH-1:0]   selWord;

  assign wrEn       = (state == FILL) && ReqAck;
  assign lastLine   = (wrCounter == {TBB_WR_ADDR_WIDTH{1'b1}});
  assign rdAccept   = RdEn && (state == READY);
  assign ReqValid   = (state == FILL);
  assign ReqLineIdx = wrCounter;
  assign Full       = (state == READY);
  assign Empty      = (state == IDLE);

  nlb_gram_sdp #(
    .ADDR_WIDTH(TBB_WR_ADDR_WIDTH),
    .DATA_WIDTH(TBB_WR_DATA_WIDTH)
  ) uRam (
    .clk  (clk),
    .we   (wrEn),
    .waddr(wrCounter),
    .din  (WrDin),
    .re   (rdAccept),
    .raddr(RdAddr[TBB_RD_ADDR_WIDTH-1:SelWidth]),
    .dout (ramDout)
  );

  // Next-state logic; illegal one-hot codes fall back to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (load_start) nextState = FILL;
        else            nextState = IDLE;
      end
      FILL: begin
        if (wrEn && lastLine) nextState = READY;
        else                  nextState = FILL;
      end
      READY: begin
        if (task_done) nextState = IDLE;
        else           nextState = READY;
      end
      default: nextState = IDLE;
    endcase
  end

  // State, line counter and end-of-batch pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wrCounter <= '0;
      TestCmp   <= 1'b0;
    end else begin
      state   <= nextState;
      TestCmp <= wrEn && lastLine;
      if (wrEn) wrCounter <= wrCounter + TBB_WR_ADDR_WIDTH'(1);
    end
  end

  // Word 0 sits in the MSBs of a line, matching the result buffer packing.
  always_comb begin
    selWord = TBB_RD_DATA_WIDTH'(ramDout >> (TBB_RD_DATA_WIDTH * (NumWords - 1 - int'(wordSel1))));
  end

  // Two-stage read pipeline: BRAM read, then word mux into RdDout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdValid1 <= 1'b0;
      wordSel1 <= '0;
      RdValid  <= 1'b0;
      RdDout   <= '0;
    end else begin
      rdValid1 <= rdAccept;
      RdValid  <= rdValid1;
      if (rdAccept) wordSel1 <= RdAddr[SelWidth-1:0];
      if (rdValid1) RdDout <= selWord;
    end
  end

endmodule

// File: tb/tb_tbb.sv
// Randomized self-checking bench for tbb against a line-array reference model.

module tb_tbb;

  logic         clk;
  logic         reset_n;
  logic         load_start;
  logic         ReqValid;
  logic [7:0]   ReqLineIdx;
  logic         ReqAck;
  logic [511:0] WrDin;
  logic         RdEn;
  logic [11:0]  RdAddr;
  logic [31:0]  RdDout;
  logic         RdValid;
  logic         task_done;
  logic         Full;
  logic         Empty;
  logic         TestCmp;

  int nCmp = 0;
  int nBad = 0;

  logic [511:0] model [256];
  bit           expectReady = 1'b0;
  bit           prevV = 1'b0;
  logic [31:0]  prevD = 32'd0;
  logic [31:0]  lastD = 32'd0;

  tbb dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .ReqValid(ReqValid), .ReqLineIdx(ReqLineIdx), .ReqAck(ReqAck), .WrDin(WrDin),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdDout(RdDout), .RdValid(RdValid),
    .task_done(task_done), .Full(Full), .Empty(Empty), .TestCmp(TestCmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] patLine(input int i);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = 32'((i << 4) | k);
    return l;
  endfunction

  function automatic logic [511:0] rndLine();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] expWord(input logic [11:0] a);
    logic [511:0] l;
    l = model[a[11:4]];
    return l[511-32*int'(a[3:0]) -: 32];
  endfunction

  // One clock; the bench predicts every read result from the model and checks it.
  task automatic tick();
    bit          accV;
    logic [31:0] accD;
    accV = RdEn && expectReady;
    accD = expWord(RdAddr);
    @(posedge clk);
    #1;
    nCmp++;
    if (RdValid !== prevV) begin
      nBad++;
      $display("FAIL rd_valid: got %b want %b at %0t", RdValid, prevV, $time);
    end
    nCmp++;
    if (prevV) begin
      if (RdDout !== prevD) begin
        nBad++;
        $display("FAIL rd_data: got %h want %h at %0t", RdDout, prevD, $time);
      end
      lastD = prevD;
    end else if (RdDout !== lastD) begin
      nBad++;
      $display("FAIL rd_hold: got %h want %h at %0t", RdDout, lastD, $time);
    end
    prevV = accV;
    prevD = accD;
  endtask

  task automatic pulseReset();
    #3;
    reset_n = 1'b0;
    #1;
    nCmp++;
    if (Empty !== 1'b1 || Full !== 1'b0 || ReqValid !== 1'b0 || RdValid !== 1'b0 ||
        TestCmp !== 1'b0 || RdDout !== 32'd0 || ReqLineIdx !== 8'd0) begin
      nBad++;
      $display("FAIL reset_outputs: got E%b F%b RV%b V%b T%b D%h I%0d want E1 F0 RV0 V0 T0 D0 I0",
               Empty, Full, ReqValid, RdValid, TestCmp, RdDout, ReqLineIdx);
    end
    load_start = 1'b0; ReqAck = 1'b0; RdEn = 1'b0; task_done = 1'b0;
    prevV = 1'b0; lastD = 32'd0; expectReady = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  // Fetch a whole batch; line data is either the address pattern or random.
  task automatic doFill(input bit throttle, input bit rnd);
    int cnt;
    int cyc;
    logic [511:0] line;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 256 && cyc < 2000) begin
      nCmp++;
      if (ReqValid !== 1'b1 || ReqLineIdx !== 8'(cnt) || Full !== 1'b0 || TestCmp !== 1'b0) begin
        nBad++;
        $display("FAIL fill_req: got RV%b idx %0d F%b T%b want RV1 idx %0d F0 T0",
                 ReqValid, ReqLineIdx, Full, TestCmp, cnt);
      end
      ReqAck = throttle ? cyc[0] : 1'b1;
      if (ReqAck) begin
        line = rnd ? rndLine() : patLine(cnt);
        model[cnt] = line;
        WrDin = line;
      end else begin
        WrDin = rndLine();
      end
      tick();
      if (ReqAck) cnt++;
      cyc++;
    end
    ReqAck = 1'b0;
    nCmp++;
    if (cnt != 256) begin
      nBad++;
      $display("FAIL fill_timeout: got %0d lines want 256", cnt);
    end
    if (!throttle) begin
      nCmp++;
      if (cyc != 256) begin
        nBad++;
        $display("FAIL fill_cycles: got %0d want 256", cyc);
      end
    end
    nCmp++;
    if (Full !== 1'b1 || TestCmp !== 1'b1 || ReqValid !== 1'b0 || Empty !== 1'b0) begin
      nBad++;
      $display("FAIL fill_done: got F%b T%b RV%b E%b want F1 T1 RV0 E0", Full, TestCmp, ReqValid, Empty);
    end
    expectReady = 1'b1;
    tick();
    nCmp++;
    if (TestCmp !== 1'b0 || Full !== 1'b1) begin
      nBad++;
      $display("FAIL testcmp_pulse: got T%b F%b want T0 F1", TestCmp, Full);
    end
  endtask

  task automatic randomReads(input int n);
    for (int i = 0; i < n; i++) begin
      RdEn = 1'($urandom_range(0, 3) != 0);
      RdAddr = 12'($urandom_range(0, 4095));
      tick();
    end
    RdEn = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; ReqAck = 1'b0; WrDin = '0;
    RdEn = 1'b0; RdAddr = 12'd0; task_done = 1'b0;
    #22;
    reset_n = 1'b1;
    tick();
    nCmp++;
    if (Empty !== 1'b1 || Full !== 1'b0 || ReqValid !== 1'b0 || RdValid !== 1'b0 || TestCmp !== 1'b0) begin
      nBad++;
      $display("FAIL reset_idle: got E%b F%b RV%b V%b T%b want E1 F0 RV0 V0 T0",
               Empty, Full, ReqValid, RdValid, TestCmp);
    end
    RdEn = 1'b1; RdAddr = 12'd0; ReqAck = 1'b1; task_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    RdEn = 1'b0; ReqAck = 1'b0; task_done = 1'b0;
    tick();
    tick();
    nCmp++;
    if (ReqValid !== 1'b0 || Empty !== 1'b1) begin
      nBad++;
      $display("FAIL idle_ignore: got RV%b E%b want RV0 E1", ReqValid, Empty);
    end
  endtask

  task automatic test_read_pipeline();
    logic [11:0] addrs [4];
    addrs[0] = 12'h000; addrs[1] = 12'h00F; addrs[2] = 12'h010; addrs[3] = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      RdEn = 1'b1;
      RdAddr = addrs[i];
      tick();
    end
    RdEn = 1'b0;
    tick();
    tick();
    randomReads(300);
  endtask

  task automatic test_release();
    RdEn = 1'b1;
    RdAddr = 12'($urandom_range(0, 4095));
    task_done = 1'b1;
    tick();
    expectReady = 1'b0;
    task_done = 1'b0;
    RdAddr = 12'h123;
    nCmp++;
    if (Full !== 1'b0 || Empty !== 1'b1) begin
      nBad++;
      $display("FAIL release: got F%b E%b want F0 E1", Full, Empty);
    end
    for (int i = 0; i < 4; i++) tick();
    RdEn = 1'b0;
    tick();
  endtask

  task automatic test_throttled();
    doFill(1'b1, 1'b0);
    for (int a = 0; a < 4096; a++) begin
      RdEn = 1'b1;
      RdAddr = 12'(a);
      tick();
    end
    RdEn = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_load_and_done();
    load_start = 1'b1;
    task_done = 1'b1;
    tick();
    expectReady = 1'b0;
    load_start = 1'b0;
    task_done = 1'b0;
    nCmp++;
    if (Empty !== 1'b1 || Full !== 1'b0) begin
      nBad++;
      $display("FAIL done_wins: got E%b F%b want E1 F0", Empty, Full);
    end
    tick();
    nCmp++;
    if (ReqValid !== 1'b0 || Empty !== 1'b1) begin
      nBad++;
      $display("FAIL done_wins_next: got RV%b E%b want RV0 E1", ReqValid, Empty);
    end
  endtask

  task automatic test_refill_random();
    doFill(1'b0, 1'b1);
    randomReads(400);
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    expectReady = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ReqAck = 1'b1;
      WrDin = rndLine();
      task_done = (i == 50);
      tick();
    end
    ReqAck = 1'b0;
    task_done = 1'b0;
    nCmp++;
    if (ReqValid !== 1'b1 || ReqLineIdx !== 8'd100) begin
      nBad++;
      $display("FAIL stray_done: got RV%b idx %0d want RV1 idx 100", ReqValid, ReqLineIdx);
    end
    pulseReset();
    tick();
    nCmp++;
    if (Empty !== 1'b1 || ReqValid !== 1'b0) begin
      nBad++;
      $display("FAIL post_reset: got E%b RV%b want E1 RV0", Empty, ReqValid);
    end
    doFill(1'b0, 1'b0);
    randomReads(100);
  endtask

  initial begin
    test_reset();
    doFill(1'b0, 1'b0);
    test_read_pipeline();
    test_release();
    test_throttled();
    test_load_and_done();
    test_refill_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
